// File: rtl/pre_pkt_fifo_pkg.sv
// pre_pkt_fifo_pkg: shared types and constants for the store-and-forward
// packet FIFO that sits in front of the sequence-number append (pre) stage.
package pre_pkt_fifo_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ENTRY_W    = DATA_W + 1;  // {tlast, tdata}
  localparam int unsigned DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/pre_pkt_fifo_sdpram.sv
// pre_pkt_fifo_sdpram: simple dual-port RAM, one write port and one
// synchronous read port (1-cycle latency). The read data register only
// updates when rd_en is high, so it holds its word otherwise.
//   clk             : clock
//   wr_en/addr/data : write port
//   rd_en/addr      : read request
//   rd_data         : registered read data
module pre_pkt_fifo_sdpram #(
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned WIDTH      = 33
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/pre_pkt_fifo.sv
// pre_pkt_fifo: store-and-forward AXI-Stream packet FIFO. Packets are
// released to the pre stage only once their tlast word is stored, so the
// output never stalls mid-frame. The source is never backpressured;
// packets that do not fit are dropped whole and counted.
//
// Build option: define PRE_PKT_FIFO_LEN_CHECK_EN to also drop packets
// longer than MAX_PKT_LEN words.
//
// Ports:
//   m_axis_aclk, m_axis_areset (async, active-high)
//   s_axis_*      : upstream AXI-Stream (tready is 1 whenever out of reset)
//   m_axis_*      : downstream AXI-Stream to pre (FWFT output register)
//   drop_count    : dropped packets, saturating
//   pkt_count     : complete packets currently stored
module pre_pkt_fifo
  import pre_pkt_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 9,
  parameter int unsigned MAX_PKT_LEN = 64
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_areset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic [DEPTH_LOG2:0]   pkt_count
);

  localparam int unsigned PW = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

  if (MAX_PKT_LEN < 1 || MAX_PKT_LEN > (2**DEPTH_LOG2)) begin : g_bad_max_len
    $error("pre_pkt_fifo: MAX_PKT_LEN out of range");
  end

  logic [PW-1:0]      wr_ptr, commit_ptr, rd_ptr;
  wr_state_e          state_q, state_d;
  logic               beat, full, len_over;
  logic               ram_we, drop_beat, commit;
  logic               rd_en, ram_vld, out_free, out_last_hs;
  logic [ENTRY_W-1:0] ram_rd_data;

  assign beat = s_axis_tvalid & s_axis_tready;
  assign full = (wr_ptr - rd_ptr) == DEPTH_WORDS;

`ifdef PRE_PKT_FIFO_LEN_CHECK_EN
  logic [PW-1:0] len_cnt;

  // len_cnt words already stored; this beat would be word len_cnt+1.
  assign len_over = len_cnt >= PW'(MAX_PKT_LEN);

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset)          len_cnt <= '0;
    else if (drop_beat || commit) len_cnt <= '0;
    else if (ram_we)            len_cnt <= len_cnt + 1'b1;
  end
`else
  assign len_over = 1'b0;
`endif

  // Write FSM: next state and per-beat actions.
  always_comb begin
    state_d   = state_q;
    ram_we    = 1'b0;
    drop_beat = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE, S_WR: begin
        if (beat) begin
          if (full || len_over) begin
            drop_beat = 1'b1;
            state_d   = s_axis_tlast ? S_IDLE : S_DROP;
          end else begin
            ram_we = 1'b1;
            if (s_axis_tlast) begin
              commit  = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_WR;
            end
          end
        end
      end
      S_DROP: begin
        if (beat && s_axis_tlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state_q       <= S_IDLE;
      s_axis_tready <= 1'b0;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      drop_count    <= '0;
    end else begin
      state_q       <= state_d;
      s_axis_tready <= 1'b1;
      if (drop_beat)   wr_ptr <= commit_ptr;
      else if (ram_we) wr_ptr <= wr_ptr + 1'b1;
      if (commit) commit_ptr <= wr_ptr + 1'b1;
      if (drop_beat && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  pre_pkt_fifo_sdpram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (ENTRY_W)
  ) u_ram (
    .clk     (m_axis_aclk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data ({s_axis_tlast, s_axis_tdata}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[DEPTH_LOG2-1:0]),
    .rd_data (ram_rd_data)
  );

  // Two-stage read pipeline: the RAM read register (ram_vld) feeds the
  // output register. A read is issued whenever the RAM stage will be free
  // at the next edge, which keeps one word in flight and gives
  // bubble-free streaming while m_axis_tready stays high.
  assign out_free    = ~m_axis_tvalid | m_axis_tready;
  assign rd_en       = (rd_ptr != commit_ptr) && (~ram_vld || out_free);
  assign out_last_hs = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      rd_ptr        <= '0;
      ram_vld       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      ram_vld <= rd_en | (ram_vld & ~out_free);
      if (out_free) begin
        m_axis_tvalid <= ram_vld;
        if (ram_vld) {m_axis_tlast, m_axis_tdata} <= ram_rd_data;
      end
      // Commit and tlast handshake in the same cycle cancel out.
      case ({commit, out_last_hs})
        2'b10:   pkt_count <= pkt_count + 1'b1;
        2'b01:   pkt_count <= pkt_count - 1'b1;
        default: pkt_count <= pkt_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pre_pkt_fifo.sv
// tb_pre_pkt_fifo: directed bench for pre_pkt_fifo. Two instances share the
// same stimulus: dut (16 words, MAX_PKT_LEN=16) and dut_len (16 words,
// MAX_PKT_LEN=4), the latter only checked in the length-limit scenario.
module tb_pre_pkt_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_tvalid, s_tlast, m_tready;
  logic [31:0] s_tdata;

  logic        s_tready, m_tvalid, m_tlast;
  logic [31:0] m_tdata;
  logic [15:0] drop_cnt;
  logic [4:0]  pkt_cnt;

  logic        l_s_tready, l_tvalid, l_tlast;
  logic [31:0] l_tdata;
  logic [15:0] l_drop_cnt;
  logic [4:0]  l_pkt_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [32:0] got_q[$];
  logic [32:0] got_len_q[$];
  bit          watch_rdy = 0;
  bit          tready_low_seen = 0;

  always #5 clk = ~clk;

  pre_pkt_fifo #(.DEPTH_LOG2(4), .MAX_PKT_LEN(16)) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .drop_count    (drop_cnt),
    .pkt_count     (pkt_cnt)
  );

  pre_pkt_fifo #(.DEPTH_LOG2(4), .MAX_PKT_LEN(4)) dut_len (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (l_s_tready),
    .m_axis_tvalid (l_tvalid),
    .m_axis_tdata  (l_tdata),
    .m_axis_tlast  (l_tlast),
    .m_axis_tready (m_tready),
    .drop_count    (l_drop_cnt),
    .pkt_count     (l_pkt_cnt)
  );

  // Inputs change only at posedge+1, so a handshake seen at the negedge is
  // the one taken at the following posedge.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) got_q.push_back({m_tlast, m_tdata});
    if (!rst && l_tvalid && m_tready) got_len_q.push_back({l_tlast, l_tdata});
    if (!rst && watch_rdy && !s_tready) tready_low_seen = 1;
  end

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = last;
    tick(1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] base, input int len);
    for (int j = 0; j < len; j++) send(base + 32'(j), j == len - 1);
  endtask

  task automatic wait_words(input string tag, input int n);
    int b = 0;
    while (got_q.size() < n && b < 300) begin
      tick(1);
      b++;
    end
    check_val(tag, 64'(got_q.size()), 64'(n));
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    got_q.delete();
    got_len_q.delete();
  endtask

  initial begin
    logic [32:0] exp_len[$];
    int lat;

    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    tick(2);
    check_val("rst_s_tready", s_tready, 0);
    check_val("rst_m_tvalid", m_tvalid, 0);
    check_val("rst_m_tdata", m_tdata, 0);
    check_val("rst_m_tlast", m_tlast, 0);
    check_val("rst_drop_count", drop_cnt, 0);
    check_val("rst_pkt_count", pkt_cnt, 0);
    rst = 1'b0;
    tick(1);
    check_val("s_tready_after_rst", s_tready, 1);

    // One 4-word packet, tready high.
    m_tready = 1'b1;
    send_pkt(32'h11, 4);
    check_val("t1_pkt_count_1", pkt_cnt, 1);
    lat = 0;
    while (!m_tvalid && lat < 4) begin
      tick(1);
      lat++;
    end
    check_val("t1_latency_le2", lat <= 2, 1);
    wait_words("t1_words", 4);
    for (int i = 0; i < 4; i++)
      check_val("t1_data", got_q[i], {i == 3, 32'h11 + 32'(i)});
    tick(2);
    check_val("t1_pkt_count_0", pkt_cnt, 0);

    // Three packets (1,2,3 words) queued behind tready low.
    got_q.delete();
    m_tready = 1'b0;
    send_pkt(32'h21, 1);
    send_pkt(32'h31, 2);
    send_pkt(32'h41, 3);
    tick(4);
    check_val("t2_pkt_count_3", pkt_cnt, 3);
    check_val("t2_m_tvalid", m_tvalid, 1);
    check_val("t2_head_data", m_tdata, 32'h21);
    check_val("t2_head_last", m_tlast, 1);
    check_val("t2_nothing_out", got_q.size(), 0);
    tick(3);
    check_val("t2_hold_data", m_tdata, 32'h21);
    m_tready = 1'b1;
    wait_words("t2_words", 6);
    check_val("t2_w0", got_q[0], {1'b1, 32'h21});
    check_val("t2_w1", got_q[1], {1'b0, 32'h31});
    check_val("t2_w2", got_q[2], {1'b1, 32'h32});
    check_val("t2_w3", got_q[3], {1'b0, 32'h41});
    check_val("t2_w4", got_q[4], {1'b0, 32'h42});
    check_val("t2_w5", got_q[5], {1'b1, 32'h43});
    tick(2);
    check_val("t2_pkt_count_0", pkt_cnt, 0);

    // Overflow: two 10-word packets into 16 words, tready low.
    do_reset();
    watch_rdy = 1;
    tready_low_seen = 0;
    send_pkt(32'h100, 10);
    send_pkt(32'h200, 10);
    tick(2);
    check_val("t3_drop_count", drop_cnt, 1);
    check_val("t3_pkt_count", pkt_cnt, 1);
    m_tready = 1'b1;
    wait_words("t3_words", 10);
    tick(20);
    check_val("t3_no_extra", got_q.size(), 10);
    for (int i = 0; i < 10; i++)
      check_val("t3_data", got_q[i], {i == 9, 32'h100 + 32'(i)});
    watch_rdy = 0;
    check_val("t3_s_tready_never_low", tready_low_seen, 0);
    check_val("t3_pkt_count_0", pkt_cnt, 0);

    // Length limit: 6-word packet then 2-word packet.
    do_reset();
    m_tready = 1'b1;
    send_pkt(32'h51, 6);
    send_pkt(32'h61, 2);
    wait_words("t4_words", 8);
    tick(10);
    check_val("t4_no_extra", got_q.size(), 8);
    for (int i = 0; i < 6; i++)
      check_val("t4_data_a", got_q[i], {i == 5, 32'h51 + 32'(i)});
    check_val("t4_data_b0", got_q[6], {1'b0, 32'h61});
    check_val("t4_data_b1", got_q[7], {1'b1, 32'h62});
    check_val("t4_drop_count", drop_cnt, 0);
`ifdef PRE_PKT_FIFO_LEN_CHECK_EN
    check_val("t4_len_drop_count", l_drop_cnt, 1);
`else
    for (int i = 0; i < 6; i++) exp_len.push_back({i == 5, 32'h51 + 32'(i)});
    check_val("t4_len_drop_count", l_drop_cnt, 0);
`endif
    exp_len.push_back({1'b0, 32'h61});
    exp_len.push_back({1'b1, 32'h62});
    check_val("t4_len_count", got_len_q.size(), exp_len.size());
    for (int i = 0; i < exp_len.size(); i++)
      check_val("t4_len_data", got_len_q[i], exp_len[i]);

    // Pointer wrap: 50 back-to-back 3-word packets.
    do_reset();
    m_tready = 1'b1;
    for (int p = 0; p < 50; p++) send_pkt(32'h1000 + 32'(p * 3), 3);
    wait_words("t5_words", 150);
    tick(5);
    check_val("t5_no_extra", got_q.size(), 150);
    for (int i = 0; i < 150; i++)
      check_val("t5_data", got_q[i], {(i % 3) == 2, 32'h1000 + 32'(i)});
    check_val("t5_drop_count", drop_cnt, 0);
    check_val("t5_pkt_count", pkt_cnt, 0);

    // Reset mid-packet with one packet queued.
    do_reset();
    send_pkt(32'h71, 2);
    send(32'h81, 1'b0);
    send(32'h82, 1'b0);
    tick(2);
    check_val("t6_queued_valid", m_tvalid, 1);
    check_val("t6_queued_pkt", pkt_cnt, 1);
    #2;
    rst = 1'b1;
    #1;
    check_val("t6_async_m_tvalid", m_tvalid, 0);
    check_val("t6_async_m_tdata", m_tdata, 0);
    check_val("t6_async_m_tlast", m_tlast, 0);
    check_val("t6_async_pkt", pkt_cnt, 0);
    check_val("t6_async_s_tready", s_tready, 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    got_q.delete();
    m_tready = 1'b1;
    send_pkt(32'h91, 2);
    wait_words("t6_words", 2);
    tick(10);
    check_val("t6_no_extra", got_q.size(), 2);
    check_val("t6_w0", got_q[0], {1'b0, 32'h91});
    check_val("t6_w1", got_q[1], {1'b1, 32'h92});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
